// File: rtl/mem_port_responder.sv
// Port 1: instruction fetch, 1-cycle read, always accepts. Port 2: data load/store, completes
// WAIT_CYCLES+1 edges after acceptance, holds mem_BUSY meanwhile and ignores requests while busy.
module mem_port_responder #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mem_RDEN1,
   input  logic [31:0] mem_ADDR1,
   output logic [31:0] mem_DOUT1,
   output logic        mem_VALID1,
   input  logic        mem_RDEN2,
   input  logic        mem_WE2,
   input  logic [31:0] mem_ADDR2,
   input  logic [31:0] mem_DIN2,
   input  logic [1:0]  mem_SIZE,
   input  logic        mem_SIGN,
   output logic [31:0] mem_DOUT2,
   output logic        mem_VALID2,
   output logic        mem_BUSY,
   output logic        mem_ERR
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] DEPTH_L = 32'(DEPTH_WORDS);

   typedef enum logic {S_IDLE, S_WAIT} state_t;

   logic [31:0] ram_q [DEPTH_WORDS];

   // ---------------- port 1 ----------------
   logic [31:0] dout1_q, dout1_d;
   logic        valid1_q, valid1_d;
   logic [31:0] widx1;
   logic [31:0] rd1_word;
   logic        unused_addr1;

   assign widx1        = {2'b00, mem_ADDR1[31:2]};
   assign unused_addr1 = ^mem_ADDR1[1:0];

   always_comb begin
      rd1_word = 32'h0;
      if (widx1 < DEPTH_L) begin
         rd1_word = ram_q[mem_ADDR1[AW+1:2]];
      end
      dout1_d  = mem_RDEN1 ? rd1_word : dout1_q;
      valid1_d = mem_RDEN1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout1_q  <= 32'h0;
         valid1_q <= 1'b0;
      end else begin
         dout1_q  <= dout1_d;
         valid1_q <= valid1_d;
      end
   end

   // ---------------- port 2 ----------------
   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic [AW-1:0]  idx_q, idx_d;
   logic [1:0]     lane_q, lane_d;
   logic [31:0]    din_q, din_d;
   logic [1:0]     size_q, size_d;
   logic           sign_q, sign_d;
   logic           we_q, we_d;
   logic [31:0]    dout2_q, dout2_d;
   logic           valid2_q, valid2_d;
   logic           busy_q, busy_d;
   logic           err_q, err_d;

   logic        req2;
   logic        bad2;
   logic [31:0] widx2;
   logic [31:0] cur_word;
   logic [31:0] byte_sh, half_sh;
   logic [31:0] load_ext;
   logic [3:0]  be;
   logic [31:0] wdat;
   logic [31:0] ram_wdat;
   logic        ram_we;

   assign req2  = mem_RDEN2 | mem_WE2;
   assign widx2 = {2'b00, mem_ADDR2[31:2]};

   always_comb begin
      bad2 = 1'b0;
      if (mem_RDEN2 && mem_WE2)                           bad2 = 1'b1;
      if (mem_SIZE == 2'b11)                              bad2 = 1'b1;
      if (mem_SIZE == 2'b01 && mem_ADDR2[0])              bad2 = 1'b1;
      if (mem_SIZE == 2'b10 && mem_ADDR2[1:0] != 2'b00)   bad2 = 1'b1;
      if (widx2 >= DEPTH_L)                               bad2 = 1'b1;
   end

   assign cur_word = ram_q[idx_q];
   assign byte_sh  = cur_word >> {lane_q, 3'b000};
   assign half_sh  = cur_word >> {lane_q[1], 4'b0000};

   always_comb begin
      case (size_q)
         2'b00:   load_ext = {{24{sign_q & byte_sh[7]}}, byte_sh[7:0]};
         2'b01:   load_ext = {{16{sign_q & half_sh[15]}}, half_sh[15:0]};
         default: load_ext = cur_word;
      endcase
   end

   // Stores are a read-modify-write of the addressed word so untouched lanes survive.
   always_comb begin
      be       = 4'b1111;
      wdat     = din_q;
      ram_wdat = cur_word;
      case (size_q)
         2'b00: begin
            be   = 4'b0001 << lane_q;
            wdat = {4{din_q[7:0]}};
         end
         2'b01: begin
            be   = lane_q[1] ? 4'b1100 : 4'b0011;
            wdat = {2{din_q[15:0]}};
         end
         default: begin
            be   = 4'b1111;
            wdat = din_q;
         end
      endcase
      for (int i = 0; i < 4; i++) begin
         if (be[i]) ram_wdat[8*i +: 8] = wdat[8*i +: 8];
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      idx_d    = idx_q;
      lane_d   = lane_q;
      din_d    = din_q;
      size_d   = size_q;
      sign_d   = sign_q;
      we_d     = we_q;
      dout2_d  = dout2_q;
      valid2_d = 1'b0;
      busy_d   = busy_q;
      err_d    = 1'b0;
      ram_we   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req2) begin
               if (bad2) begin
                  err_d = 1'b1;
               end else begin
                  idx_d   = mem_ADDR2[AW+1:2];
                  lane_d  = mem_ADDR2[1:0];
                  din_d   = mem_DIN2;
                  size_d  = mem_SIZE;
                  sign_d  = mem_SIGN;
                  we_d    = mem_WE2;
                  cnt_d   = 4'(WAIT_CYCLES);
                  busy_d  = 1'b1;
                  state_d = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               ram_we   = we_q;
               valid2_d = 1'b1;
               busy_d   = 1'b0;
               state_d  = S_IDLE;
               if (!we_q) dout2_d = load_ext;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         cnt_q    <= 4'd0;
         idx_q    <= '0;
         lane_q   <= 2'b00;
         din_q    <= 32'h0;
         size_q   <= 2'b00;
         sign_q   <= 1'b0;
         we_q     <= 1'b0;
         dout2_q  <= 32'h0;
         valid2_q <= 1'b0;
         busy_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         idx_q    <= idx_d;
         lane_q   <= lane_d;
         din_q    <= din_d;
         size_q   <= size_d;
         sign_q   <= sign_d;
         we_q     <= we_d;
         dout2_q  <= dout2_d;
         valid2_q <= valid2_d;
         busy_q   <= busy_d;
         err_q    <= err_d;
      end
   end

   // RAM contents survive reset; ram_we is gated by the reset state register.
   always_ff @(posedge clk) begin
      if (ram_we) ram_q[idx_q] <= ram_wdat;
   end

   assign mem_DOUT1  = dout1_q;
   assign mem_VALID1 = valid1_q;
   assign mem_DOUT2  = dout2_q;
   assign mem_VALID2 = valid2_q;
   assign mem_BUSY   = busy_q;
   assign mem_ERR    = err_q;

endmodule

// File: tb/tb_mem_port_responder.sv
// Bench: instance 0 runs WAIT_CYCLES=2, instance 1 runs WAIT_CYCLES=0; a byte-addressed model
// supplies expected port-2 errors, load data and port-1 words.
module tb_mem_port_responder;

   localparam int DEPTH = 1024;
   localparam int NBYTE = DEPTH * 4;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        rden1  [2];
   logic [31:0] addr1  [2];
   logic [31:0] dout1  [2];
   logic        valid1 [2];
   logic        rden2  [2];
   logic        we2    [2];
   logic [31:0] addr2  [2];
   logic [31:0] din2   [2];
   logic [1:0]  size   [2];
   logic        sign   [2];
   logic [31:0] dout2  [2];
   logic        valid2 [2];
   logic        busy   [2];
   logic        err    [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      mem_port_responder #(
         .DEPTH_WORDS(DEPTH),
         .WAIT_CYCLES(g == 0 ? 2 : 0)
      ) dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .mem_RDEN1 (rden1[g]),
         .mem_ADDR1 (addr1[g]),
         .mem_DOUT1 (dout1[g]),
         .mem_VALID1(valid1[g]),
         .mem_RDEN2 (rden2[g]),
         .mem_WE2   (we2[g]),
         .mem_ADDR2 (addr2[g]),
         .mem_DIN2  (din2[g]),
         .mem_SIZE  (size[g]),
         .mem_SIGN  (sign[g]),
         .mem_DOUT2 (dout2[g]),
         .mem_VALID2(valid2[g]),
         .mem_BUSY  (busy[g]),
         .mem_ERR   (err[g])
      );
   end

   int errors = 0;
   int checks = 0;

   logic [7:0]  bm [2][0:NBYTE-1];
   logic [31:0] exp_d2 [2];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic int wait_of(input int u);
      return (u == 0) ? 2 : 0;
   endfunction

   function automatic logic model_err(input logic rd, input logic we, input logic [31:0] a,
                                      input logic [1:0] sz);
      if (rd && we) return 1'b1;
      if (sz == 2'b11) return 1'b1;
      if (a % (1 << sz) != 0) return 1'b1;
      if (a >= NBYTE) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_load(input int u, input logic [31:0] a,
                                              input logic [1:0] sz, input logic sg);
      int     n = 1 << sz;
      longint v = 0;
      for (int i = 0; i < n; i++) v = v + (longint'(bm[u][a + i]) << (8 * i));
      if (sg && ((v >> (8 * n - 1)) & 1) != 0) v = v - (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   task automatic model_store(input int u, input logic [31:0] a, input logic [1:0] sz,
                              input logic [31:0] d);
      for (int i = 0; i < (1 << sz); i++) bm[u][a + i] = d[8*i +: 8];
   endtask

   function automatic logic [31:0] model_word(input int u, input logic [31:0] a);
      int base = int'(a) / 4 * 4;
      if (a >= NBYTE) return 32'h0;
      return {bm[u][base + 3], bm[u][base + 2], bm[u][base + 1], bm[u][base]};
   endfunction

   // One port-2 request, followed through to its error pulse or completion.
   task automatic p2_op(input int u, input logic rd, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] sz, input logic sg,
                        output logic got_err, output logic [31:0] got_dout);
      logic me;
      int   n;
      me = model_err(rd, we, a, sz);
      @(negedge clk);
      chk("valid2_pulse", valid2[u], 0);
      rden2[u] = rd; we2[u] = we; addr2[u] = a; din2[u] = d; size[u] = sz; sign[u] = sg;
      @(negedge clk);
      rden2[u] = 1'b0; we2[u] = 1'b0;
      got_err  = err[u];
      got_dout = dout2[u];
      chk("p2_err", got_err, me);
      if (got_err) begin
         chk("err_busy", busy[u], 0);
         chk("err_valid", valid2[u], 0);
         @(negedge clk);
         chk("err_pulse", err[u], 0);
         chk("err_valid2", valid2[u], 0);
         chk("err_busy2", busy[u], 0);
      end else begin
         n = 0;
         while (!valid2[u] && n < 40) begin
            chk("busy_hold", busy[u], 1);
            n++;
            @(negedge clk);
         end
         chk("latency", n, wait_of(u) + 1);
         chk("busy_drop", busy[u], 0);
         got_dout = dout2[u];
         if (!me) begin
            if (we) begin
               model_store(u, a, sz, d);
            end else begin
               exp_d2[u] = model_load(u, a, sz, sg);
            end
            chk("dout2", got_dout, exp_d2[u]);
         end
      end
   endtask

   task automatic p1_read(input int u, input logic [31:0] a, input logic [31:0] exp,
                          input string nm);
      @(negedge clk);
      rden1[u] = 1'b1; addr1[u] = a;
      @(negedge clk);
      rden1[u] = 1'b0;
      chk({nm, "_v"}, valid1[u], 1);
      chk({nm, "_d"}, dout1[u], exp);
      @(negedge clk);
      chk({nm, "_pulse"}, valid1[u], 0);
      chk({nm, "_hold"}, dout1[u], exp);
   endtask

   typedef struct packed {
      logic        rd;
      logic        we;
      logic [31:0] a;
      logic [31:0] d;
      logic [1:0]  sz;
      logic        sg;
      logic        e;
      logic [31:0] q;
   } vec_t;

   function automatic vec_t mk(input logic rd, input logic we, input logic [31:0] a,
                               input logic [31:0] d, input logic [1:0] sz, input logic sg,
                               input logic e, input logic [31:0] q);
      vec_t v;
      v.rd = rd; v.we = we; v.a = a; v.d = d; v.sz = sz; v.sg = sg; v.e = e; v.q = q;
      return v;
   endfunction

   initial begin
      vec_t        tbl [$];
      logic        ge;
      logic [31:0] gq;
      logic        rd, we, sg;
      logic [1:0]  sz;
      logic [31:0] a;
      int          n;

      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         rden1[u] = 0; addr1[u] = 0; rden2[u] = 0; we2[u] = 0;
         addr2[u] = 0; din2[u] = 0; size[u] = 0; sign[u] = 0; exp_d2[u] = 0;
      end
      repeat (2) @(negedge clk);
      for (int u = 0; u < 2; u++) begin
         chk("rst_dout1", dout1[u], 0);
         chk("rst_valid1", valid1[u], 0);
         chk("rst_dout2", dout2[u], 0);
         chk("rst_valid2", valid2[u], 0);
         chk("rst_busy", busy[u], 0);
         chk("rst_err", err[u], 0);
      end
      rst_n = 1'b1;

      // Instruction fetch of a preloaded word, plus ignored low bits and out-of-range index.
      p2_op(0, 0, 1, 32'h0, 32'h0050_0093, 2'b10, 0, ge, gq);
      p1_read(0, 32'h0, 32'h0050_0093, "p1_fetch");
      p1_read(0, 32'h3, 32'h0050_0093, "p1_lowbits");
      p1_read(0, 32'h1000, 32'h0, "p1_range");

      tbl.push_back(mk(0, 1, 32'h10, 32'hDEAD_BEEF, 2'b10, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h13, 32'h0,         2'b00, 1, 0, 32'hFFFF_FFDE));
      tbl.push_back(mk(1, 0, 32'h13, 32'h0,         2'b00, 0, 0, 32'h0000_00DE));
      tbl.push_back(mk(0, 1, 32'h12, 32'h0000_1234, 2'b01, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'h1234_BEEF));
      tbl.push_back(mk(1, 0, 32'h11, 32'h0,         2'b01, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'h1234_BEEF));
      tbl.push_back(mk(1, 1, 32'h10, 32'h0,         2'b10, 0, 1, 32'h0));
      tbl.push_back(mk(0, 1, 32'h10, 32'h0,         2'b11, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 32'h1000, 32'h0,       2'b10, 0, 1, 32'h0));
      tbl.push_back(mk(1, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'h1234_BEEF));
      tbl.push_back(mk(1, 0, 32'h10, 32'h0,         2'b01, 1, 0, 32'hFFFF_BEEF));
      tbl.push_back(mk(1, 0, 32'h12, 32'h0,         2'b01, 1, 0, 32'h0000_1234));
      tbl.push_back(mk(0, 1, 32'h11, 32'hAAAA_AA55, 2'b00, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 32'h10, 32'h0,         2'b10, 0, 0, 32'h1234_55EF));
      tbl.push_back(mk(1, 0, 32'h10, 32'h0,         2'b00, 1, 0, 32'hFFFF_FFEF));
      tbl.push_back(mk(1, 0, 32'h12, 32'h0,         2'b10, 0, 1, 32'h0));
      for (int i = 0; i < tbl.size(); i++) begin
         p2_op(0, tbl[i].rd, tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].sz, tbl[i].sg, ge, gq);
         chk($sformatf("tbl%0d_err", i), ge, tbl[i].e);
         if (!tbl[i].e && tbl[i].rd) chk($sformatf("tbl%0d_dout", i), gq, tbl[i].q);
      end

      // Reset in the middle of a store's wait: the store must never land.
      p2_op(0, 0, 1, 32'h20, 32'h0, 2'b10, 0, ge, gq);
      @(negedge clk);
      we2[0] = 1; addr2[0] = 32'h20; din2[0] = 32'hCAFE_F00D; size[0] = 2'b10;
      @(negedge clk);
      we2[0] = 0;
      chk("rst_mid_busy", busy[0], 1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int u = 0; u < 2; u++) begin
         chk("arst_dout1", dout1[u], 0);
         chk("arst_valid1", valid1[u], 0);
         chk("arst_dout2", dout2[u], 0);
         chk("arst_valid2", valid2[u], 0);
         chk("arst_busy", busy[u], 0);
         chk("arst_err", err[u], 0);
      end
      exp_d2[0] = 0; exp_d2[1] = 0;
      repeat (2) begin
         @(negedge clk);
         chk("arst_novalid", valid2[0], 0);
      end
      rst_n = 1'b1;
      rden2[0] = 1; addr2[0] = 32'h20; size[0] = 2'b10; sign[0] = 0;
      @(negedge clk);
      rden2[0] = 0;
      chk("rst_accept", busy[0], 1);
      n = 0;
      while (!valid2[0] && n < 40) begin
         n++;
         @(negedge clk);
      end
      chk("rst_load_lat", n, 3);
      chk("rst_load_old", dout2[0], 32'h0);

      // Zero-wait instance: back-to-back loads and read-before-write on port 1.
      p2_op(1, 0, 1, 32'h10, 32'h1111_1111, 2'b10, 0, ge, gq);
      p2_op(1, 0, 1, 32'h14, 32'h2222_2222, 2'b10, 0, ge, gq);
      @(negedge clk);
      rden2[1] = 1; addr2[1] = 32'h10; size[1] = 2'b10; sign[1] = 0;
      @(negedge clk);
      rden2[1] = 0;
      chk("bb_busy_a", busy[1], 1);
      chk("bb_nvalid_a", valid2[1], 0);
      @(negedge clk);
      chk("bb_valid_a", valid2[1], 1);
      chk("bb_dout_a", dout2[1], 32'h1111_1111);
      chk("bb_idle_a", busy[1], 0);
      rden2[1] = 1; addr2[1] = 32'h14;
      @(negedge clk);
      rden2[1] = 0;
      chk("bb_busy_b", busy[1], 1);
      chk("bb_nvalid_b", valid2[1], 0);
      @(negedge clk);
      chk("bb_valid_b", valid2[1], 1);
      chk("bb_dout_b", dout2[1], 32'h2222_2222);
      chk("bb_idle_b", busy[1], 0);
      exp_d2[1] = 32'h2222_2222;

      @(negedge clk);
      we2[1] = 1; addr2[1] = 32'h10; din2[1] = 32'h3333_3333; size[1] = 2'b10;
      @(negedge clk);
      we2[1] = 0;
      rden1[1] = 1; addr1[1] = 32'h10;
      chk("rbw_busy", busy[1], 1);
      @(negedge clk);
      rden1[1] = 0;
      chk("rbw_valid2", valid2[1], 1);
      chk("rbw_valid1", valid1[1], 1);
      chk("rbw_old", dout1[1], 32'h1111_1111);
      model_store(1, 32'h10, 2'b10, 32'h3333_3333);
      p1_read(1, 32'h10, 32'h3333_3333, "rbw_new");

      // Randomised traffic over a known-initialised region against the byte model.
      for (int u = 0; u < 2; u++) begin
         for (int w = 32'h100; w < 32'h200; w += 4) p2_op(u, 0, 1, w, 32'h0, 2'b10, 0, ge, gq);
         for (int i = 0; i < 150; i++) begin
            n  = $urandom_range(0, 9);
            rd = (n == 0) || (n < 5);
            we = (n == 0) || (n >= 5);
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = ($urandom_range(0, 15) == 0) ? 32'h1000 + $urandom_range(0, 255)
                                               : 32'h100 + $urandom_range(0, 255);
            sg = 1'($urandom_range(0, 1));
            p2_op(u, rd, we, a, $urandom, sz, sg, ge, gq);
         end
         for (int w = 32'h100; w < 32'h200; w += 4) p1_read(u, w, model_word(u, w), "rnd_p1");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
